// File: rtl/sca_blk_alloc.sv
// Free-list allocator for the shared SCA capacitor blocks: a circular FIFO of free
// block numbers plus an in-use bitmap, optionally triplicated control state.
module sca_blk_alloc #(
    parameter int NBLK      = 16,
    parameter int AW        = 4,
    parameter int AFULL_THR = 2,
    parameter int TMR       = 0
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          FLUSH,
    input  logic          ALLOC_REQ,
    output logic          ALLOC_GNT,
    output logic [AW-1:0] ALLOC_BLK,
    output logic          ALLOC_FAIL,
    input  logic          FREE_REQ,
    input  logic [AW-1:0] FREE_BLK,
    output logic          FREE_ACK,
    output logic          ERR_DBLFREE,
    output logic [AW:0]   NFREE,
    output logic          SCAFULL,
    output logic          ALMOST_FULL,
    output logic          READY
);

    typedef enum logic {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    // All control state lives in one packed word so it can be triplicated and voted as a unit.
    typedef struct packed {
        state_t          state;
        logic [AW-1:0]   cnt;
        logic [AW-1:0]   rd_ptr;
        logic [AW-1:0]   wr_ptr;
        logic [AW:0]     nfree;
        logic [NBLK-1:0] bitmap;
    } ctx_t;

    localparam int CW    = $bits(ctx_t);
    localparam int NCOPY = (TMR != 0) ? 3 : 1;

    logic [CW-1:0] ctx_q [NCOPY];
    logic [CW-1:0] voted;
    ctx_t          cur;
    ctx_t          nxt;

    logic [AW-1:0] fifo [NBLK];
    logic          fifo_we;
    logic [AW-1:0] fifo_waddr;
    logic [AW-1:0] fifo_wdata;
    logic [AW-1:0] pop_blk;
    logic          push;
    logic          pop;
    logic          gnt_d;
    logic          fail_d;
    logic          ack_d;
    logic          err_d;

    if (TMR != 0) begin : g_tmr
        assign voted = (ctx_q[0] & ctx_q[1]) | (ctx_q[0] & ctx_q[2]) | (ctx_q[1] & ctx_q[2]);
    end else begin : g_single
        assign voted = ctx_q[0];
    end

    assign cur     = ctx_t'(voted);
    assign pop_blk = fifo[cur.rd_ptr];

    // NOTE: state registers use non-blocking assignments so every copy samples the same pre-edge value.
    always_ff @(posedge CLK or posedge RST) begin
        for (int i = 0; i < NCOPY; i++) begin
            if (RST) ctx_q[i] <= '0;
            else     ctx_q[i] <= nxt;
        end
    end

    // NOTE: every signal gets a default before the branches, otherwise latches are inferred.
    always_comb begin
        nxt        = cur;
        push       = 1'b0;
        pop        = 1'b0;
        fifo_we    = 1'b0;
        fifo_waddr = '0;
        fifo_wdata = '0;
        gnt_d      = 1'b0;
        fail_d     = 1'b0;
        ack_d      = 1'b0;
        err_d      = 1'b0;

        if (FLUSH) begin
            nxt    = '0;
            fail_d = ALLOC_REQ;
        end else if (cur.state == S_INIT) begin
            fifo_we    = 1'b1;
            fifo_waddr = cur.cnt;
            fifo_wdata = cur.cnt;
            nxt.cnt    = cur.cnt + 1'b1;
            fail_d     = ALLOC_REQ;
            if (cur.cnt == AW'(NBLK - 1)) begin
                nxt.state  = S_RUN;
                nxt.nfree  = (AW+1)'(NBLK);
                nxt.wr_ptr = '0;
            end
        end else begin
            if (ALLOC_REQ) begin
                if (cur.nfree != '0) begin
                    pop                 = 1'b1;
                    gnt_d               = 1'b1;
                    nxt.rd_ptr          = cur.rd_ptr + 1'b1;
                    nxt.bitmap[pop_blk] = 1'b1;
                end else begin
                    fail_d = 1'b1;
                end
            end
            // Free checks the pre-cycle bitmap, so freeing the block being granted is an error.
            if (FREE_REQ) begin
                if (cur.bitmap[FREE_BLK]) begin
                    push                 = 1'b1;
                    ack_d                = 1'b1;
                    fifo_we              = 1'b1;
                    fifo_waddr           = cur.wr_ptr;
                    fifo_wdata           = FREE_BLK;
                    nxt.wr_ptr           = cur.wr_ptr + 1'b1;
                    nxt.bitmap[FREE_BLK] = 1'b0;
                end else begin
                    err_d = 1'b1;
                end
            end
            nxt.nfree = cur.nfree + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    // NOTE: the FIFO storage is not reset; INIT rewrites every entry before it can be read.
    always_ff @(posedge CLK) begin
        if (fifo_we) fifo[fifo_waddr] <= fifo_wdata;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ALLOC_GNT   <= 1'b0;
            ALLOC_BLK   <= '0;
            ALLOC_FAIL  <= 1'b0;
            FREE_ACK    <= 1'b0;
            ERR_DBLFREE <= 1'b0;
        end else begin
            ALLOC_GNT   <= gnt_d;
            ALLOC_FAIL  <= fail_d;
            FREE_ACK    <= ack_d;
            ERR_DBLFREE <= err_d;
            if (gnt_d) ALLOC_BLK <= pop_blk;
        end
    end

    assign NFREE       = cur.nfree;
    assign READY       = (cur.state == S_RUN);
    assign SCAFULL     = READY && (cur.nfree == '0);
    assign ALMOST_FULL = READY && (cur.nfree <= (AW+1)'(AFULL_THR));

endmodule
